// File: rtl/mem_access_ctrl.sv
// Memory access sequencer: turns one load/store request into RAM strobes for
// MEM_LAT cycles, steers the MDR capture on loads, and pulses done (with err).
module mem_access_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int ADDR_W  = 9
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              wr,
  input  logic [31:0]       addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              mdr_en,
  output logic              mdr_read,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic                addr_oor;

  // Any bit above the RAM word range makes the request illegal.
  assign addr_oor = |addr[31:ADDR_W];

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (addr_oor) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            addr_d  = addr[ADDR_W-1:0];
            cnt_d   = CNT_INIT;
            err_d   = 1'b0;
            state_d = wr ? S_WR : S_RD;
          end
        end
      end
      S_RD: begin
        if (cnt_q == 4'd0) state_d = S_CAP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_CAP: state_d = S_DONE;
      S_WR: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE: begin
        state_d = S_IDLE;
        err_d   = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Mem_rd stays up through CAP so RAM data is stable at the capture edge.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    err      = (state_q == S_DONE) && err_q;
    mem_rd   = (state_q == S_RD) || (state_q == S_CAP);
    mem_wr   = (state_q == S_WR);
    mdr_en   = (state_q == S_CAP);
    mdr_read = (state_q == S_CAP);
  end

  assign mem_addr = addr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench: driver issues random/directed requests and queues the
// expected completion; a monitor checks every cycle and every done pulse.
module tb_mem_access_ctrl;
  localparam int LAT = 2;
  localparam int AW  = 9;

  logic          clk, clr, req, wr;
  logic [31:0]   addr;
  logic          busy, done, err, mdr_en, mdr_read, mem_rd, mem_wr;
  logic [AW-1:0] mem_addr;

  mem_access_ctrl #(.MEM_LAT(LAT), .ADDR_W(AW)) dut (
    .clk(clk), .clr(clr), .req(req), .wr(wr), .addr(addr),
    .busy(busy), .done(done), .err(err), .mdr_en(mdr_en), .mdr_read(mdr_read),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          done_cyc;
    logic        err;
    logic        wr;
    logic [8:0]  maddr;
    logic [31:0] data;
    int          rd_n;
    int          wr_n;
    int          en_n;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          idle_at = 0;
  logic [8:0]  last_addr = '0;
  logic [31:0] ref_mem [512];
  logic        mon_en = 1'b0;

  // Environment: RAM and MDR register driven by the DUT's strobes.
  logic [31:0] ram [512];
  logic [31:0] mdr;
  logic        ram_init, cu_load;
  logic [31:0] cu_val;

  function automatic logic [31:0] init_val(int i);
    return 32'(i) * 32'h9E3779B9 + 32'h1234;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 512; i++) ram[i] <= init_val(i);
    end else if (mem_wr === 1'b1) begin
      ram[mem_addr] <= mdr;
    end
  end

  always @(posedge clk) begin
    if (mdr_en === 1'b1 && mdr_read === 1'b1) mdr <= ram[mem_addr];
    else if (cu_load) mdr <= cu_val;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: latency and side effects of one accepted request.
  function automatic void accept(input logic w, input logic [31:0] a, input logic [31:0] v);
    exp_t e;
    int   d;
    e.wr = w; e.rd_n = 0; e.wr_n = 0; e.en_n = 0; e.data = '0;
    if (a >= 32'd512) begin
      d = 1; e.err = 1'b1; e.maddr = last_addr;
    end else begin
      e.err = 1'b0; last_addr = a[8:0]; e.maddr = a[8:0];
      if (w) begin
        d = LAT + 1; e.wr_n = LAT; ref_mem[a[8:0]] = v; e.data = v;
      end else begin
        d = LAT + 2; e.rd_n = LAT + 1; e.en_n = 1; e.data = ref_mem[a[8:0]];
      end
    end
    e.done_cyc = cyc + d;
    idle_at    = cyc + d + 1;
    q.push_back(e);
  endfunction

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r == 0) return {23'($urandom_range(1, 32'h7FFFFF)), 9'($urandom)};
    if (r == 1) return 32'h200;
    return 32'($urandom_range(0, 511));
  endfunction

  // Called at a negedge; junk on the request pins while busy must be ignored.
  task automatic do_op(input logic w, input logic [31:0] a, input logic [31:0] v);
    while (cyc < idle_at) begin
      req = 1'($urandom); wr = 1'($urandom); addr = $urandom;
      @(negedge clk);
    end
    req = 1'b1; wr = w; addr = a;
    cu_load = w; cu_val = v;
    accept(w, a, v);
    @(negedge clk);
    req = 1'b0; cu_load = 1'b0;
  endtask

  task automatic held(input int n);
    req = 1'b1; wr = 1'b0;
    for (int k = 0; k < n; k++) begin
      while (cyc < idle_at) begin
        addr = $urandom;
        @(negedge clk);
      end
      addr = 32'($urandom_range(0, 511));
      accept(1'b0, addr, '0);
      @(negedge clk);
    end
    req = 1'b0;
  endtask

  task automatic do_reset(input int n);
    clr = 1'b1; req = 1'b0; cu_load = 1'b0;
    q.delete();
    last_addr = '0;
    idle_at = cyc + 1;
    repeat (n) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_strobes", {28'd0, mdr_en, mdr_read, mem_rd, mem_wr}, 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    clr = 1'b0;
  endtask

  // Monitor: sampled 1 time unit after each rising edge.
  initial begin
    int rd_c = 0, wr_c = 0, en_c = 0;
    logic bexp, bad;
    exp_t e;
    wait (mon_en);
    forever begin
      @(posedge clk); #1;
      bexp = (cyc < idle_at);
      chk("busy", 32'(busy), 32'(bexp));
      bad = (mem_rd & mem_wr) | (mdr_en ^ mdr_read) | (!done & err) |
            (!bexp & (mem_rd | mem_wr | mdr_en | mdr_read)) |
            (done & (mem_rd | mem_wr | mdr_en | mdr_read));
      chk("strobe_rules", 32'(bad), 0);
      rd_c += int'(mem_rd); wr_c += int'(mem_wr); en_c += int'(mdr_en);
      if (clr) begin
        rd_c = 0; wr_c = 0; en_c = 0;
      end
      if (done === 1'b1 || (q.size() > 0 && q[0].done_cyc == cyc)) begin
        if (q.size() == 0) begin
          chk("spurious_done", 32'(done), 0);
        end else begin
          e = q.pop_front();
          chk("done_pulse", 32'(done), 1);
          chk("done_cycle", cyc, e.done_cyc);
          chk("err", 32'(err), 32'(e.err));
          chk("mem_addr", 32'(mem_addr), 32'(e.maddr));
          chk("mem_rd_cycles", rd_c, e.rd_n);
          chk("mem_wr_cycles", wr_c, e.wr_n);
          chk("mdr_en_cycles", en_c, e.en_n);
          if (!e.err) begin
            if (e.wr) chk("ram_data", ram[e.maddr], e.data);
            else      chk("mdr_data", mdr, e.data);
          end
        end
        rd_c = 0; wr_c = 0; en_c = 0;
      end
    end
  end

  initial begin
    clr = 1'b1; req = 1'b0; wr = 1'b0; addr = '0;
    cu_load = 1'b0; cu_val = '0; ram_init = 1'b1;
    for (int i = 0; i < 512; i++) ref_mem[i] = init_val(i);
    repeat (2) @(negedge clk);
    ram_init = 1'b0;
    do_reset(1);
    idle_at = cyc;
    mon_en = 1'b1;
    @(negedge clk);

    do_op(1'b1, 32'h5,   32'hDEADBEEF);
    do_op(1'b0, 32'h5,   32'h0);
    do_op(1'b1, 32'h1FF, 32'h12345678);
    do_op(1'b0, 32'h1FF, 32'h0);
    do_op(1'b0, 32'h200, 32'h0);
    do_op(1'b1, 32'h8000_0000, 32'h1);
    do_op(1'b0, 32'h0,   32'h0);
    held(4);

    // Reset during the second RD cycle of a load.
    do_op(1'b0, 32'h33, 32'h0);
    @(negedge clk);
    do_reset(1);
    do_op(1'b0, 32'h5, 32'h0);

    for (int n = 0; n < 150; n++) begin
      do_op(1'($urandom), rand_addr(), $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (n == 80) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        do_reset(2);
      end
      if (n % 40 == 7) held($urandom_range(2, 4));
    end

    repeat (LAT + 6) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
